// File: rtl/count_uart_tx.sv
// Snapshots a 32-bit count and sends it as four 8N1 UART bytes, MSB byte first.
// An optional one-cycle clear pulse can be sent back to the counter on capture.
module count_uart_tx #(
    parameter int CLKS_PER_BIT     = 868,
    parameter bit CLEAR_ON_CAPTURE = 1'b0
) (
    input  logic        clock,
    input  logic        i_reset,
    input  logic [31:0] i_count,
    input  logic        i_start,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_comp_reset
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] baud;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  shift;
    logic [31:0] snapshot;

    logic bit_end;
    assign bit_end = (baud == BAUD_LAST);

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state        <= IDLE;
            baud         <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            shift        <= '0;
            snapshot     <= '0;
            o_tx         <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_comp_reset <= 1'b0;
        end else begin
            o_done       <= 1'b0;
            o_comp_reset <= 1'b0;
            case (state)
                IDLE: begin
                    o_tx <= 1'b1;
                    if (i_start) begin
                        snapshot     <= i_count;
                        byte_idx     <= '0;
                        baud         <= '0;
                        state        <= START;
                        o_busy       <= 1'b1;
                        o_tx         <= 1'b0;
                        o_comp_reset <= CLEAR_ON_CAPTURE;
                    end
                end
                START: begin
                    if (bit_end) begin
                        // Snapshot shifts up a byte per load so the top byte is always next.
                        baud     <= '0;
                        shift    <= snapshot[31:24];
                        snapshot <= {snapshot[23:0], 8'h00};
                        o_tx     <= snapshot[24];
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            o_tx  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            o_tx    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (byte_idx == 2'd3) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            o_tx   <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= START;
                            o_tx     <= 1'b0;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx: two instances (clear pulse off/on) share stimulus,
// every cycle of each frame is compared against the bit expected from the 32-bit word.
module tb_count_uart_tx;
    localparam int CPB = 4;
    localparam int FRAME_CYC = 40 * CPB;

    logic        clock = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_count = '0;
    logic        i_start = 1'b0;
    logic        tx, busy, done, comp;
    logic        tx_c, busy_c, done_c, comp_c;
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    count_uart_tx #(.CLKS_PER_BIT(CPB), .CLEAR_ON_CAPTURE(1'b0)) dut (
        .clock(clock), .i_reset(i_reset), .i_count(i_count), .i_start(i_start),
        .o_tx(tx), .o_busy(busy), .o_done(done), .o_comp_reset(comp));

    count_uart_tx #(.CLKS_PER_BIT(CPB), .CLEAR_ON_CAPTURE(1'b1)) dut_clr (
        .clock(clock), .i_reset(i_reset), .i_count(i_count), .i_start(i_start),
        .o_tx(tx_c), .o_busy(busy_c), .o_done(done_c), .o_comp_reset(comp_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level for bit b (0..39) of a frame carrying word w.
    function automatic logic exp_bit(input logic [31:0] w, input int b);
        logic [7:0] byt;
        int pos;
        byt = w[31 - 8*(b/10) -: 8];
        pos = b % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return byt[pos-1];
    endfunction

    // Starts a frame at the current negedge and checks it cycle by cycle.
    task automatic frame(input string tag, input logic [31:0] w, input int chg_at,
                         input logic [31:0] chg_val, input int pulse_at,
                         input int rst_at, input bit hold);
        i_count = w;
        i_start = 1'b1;
        @(negedge clock);
        for (int c = 0; c < FRAME_CYC; c++) begin
            chk($sformatf("%s tx c%0d", tag, c), tx, exp_bit(w, c / CPB));
            chk($sformatf("%s busy c%0d", tag, c), busy, 1'b1);
            chk($sformatf("%s done c%0d", tag, c), done, 1'b0);
            chk($sformatf("%s comp0 c%0d", tag, c), comp, 1'b0);
            chk($sformatf("%s comp1 c%0d", tag, c), comp_c, (c == 0));
            chk($sformatf("%s clr_tx c%0d", tag, c), tx_c, exp_bit(w, c / CPB));
            if (c == chg_at) i_count = chg_val;
            i_start = hold || (c == pulse_at);
            if (c == rst_at) begin
                i_reset = 1'b0;
                @(negedge clock);
                chk({tag, " rst tx"}, tx, 1'b1);
                chk({tag, " rst busy"}, busy, 1'b0);
                chk({tag, " rst done"}, done, 1'b0);
                i_reset = 1'b1;
                @(negedge clock);
                chk({tag, " post tx"}, tx, 1'b1);
                chk({tag, " post busy"}, busy, 1'b0);
                chk({tag, " post done"}, done, 1'b0);
                return;
            end
            @(negedge clock);
        end
        chk({tag, " end done"}, done, 1'b1);
        chk({tag, " end busy"}, busy, 1'b0);
        chk({tag, " end tx"}, tx, 1'b1);
        chk({tag, " end comp1"}, comp_c, 1'b0);
        chk({tag, " end clr_done"}, done_c, 1'b1);
        if (!hold) begin
            @(negedge clock);
            chk({tag, " done low"}, done, 1'b0);
            chk({tag, " idle busy"}, busy, 1'b0);
            chk({tag, " idle tx"}, tx, 1'b1);
        end
    endtask

    initial begin
        i_reset = 1'b0;
        i_start = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset tx", tx, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset comp", comp_c, 1'b0);
        i_start = 1'b0;
        i_reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle tx", tx, 1'b1);
        chk("idle busy", busy, 1'b0);

        frame("basic", 32'h12345678, -1, 32'h0, -1, -1, 1'b0);
        repeat (3) @(negedge clock);
        frame("snap", 32'h000000FF, 0, 32'hFFFFFFFF, -1, -1, 1'b0);
        i_count = 32'h0;
        frame("ignore", 32'hC3_5A_0F_81, -1, 32'h0, 13 * CPB + 1, -1, 1'b0);
        repeat (4) @(negedge clock);
        chk("ignore no 2nd busy", busy, 1'b0);
        chk("ignore no 2nd tx", tx, 1'b1);
        frame("b2b1", 32'hA5A5A5A5, -1, 32'h0, -1, -1, 1'b1);
        frame("b2b2", 32'hA5A5A5A5, -1, 32'h0, -1, -1, 1'b0);
        frame("rstmid", 32'hDEADBEEF, -1, 32'h0, -1, 23 * CPB + 1, 1'b0);
        repeat (2) @(negedge clock);
        chk("rst no done", done, 1'b0);
        frame("after_rst", 32'h80000001, -1, 32'h0, -1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/count_uart_tx.md
# count_uart_tx

Serializing stage directly downstream of the 32-bit switch-gated event counter. On a start request it snapshots the counter value, emits it as four 8N1 UART bytes (most significant byte first), and optionally issues a one-cycle clear pulse back to the counter's compare-reset input. This lets the board report the current count to a host terminal without stopping the counter.

## Interface
- CLKS_PER_BIT, default 868 — clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
- CLEAR_ON_CAPTURE, default 0 — 1: pulse o_comp_reset on the snapshot cycle; 0: o_comp_reset tied low.

- clock  input  1  system clock; all logic on rising edge.
- i_reset  input  1  reset, synchronous, active-low.
- i_count  input  32  counter value to snapshot.
- i_start  input  1  transmit request; level-sampled, acted on only in IDLE.
- o_tx  output  1  UART TX line; idle high.
- o_busy  output  1  high while a 4-byte frame is in progress.
- o_done  output  1  one-cycle pulse when the final stop bit completes.
- o_comp_reset  output  1  one-cycle clear request to the upstream counter.

## Operation
- Reset (i_reset==0 at a rising edge): state=IDLE, o_tx=1, o_busy=0, o_done=0, o_comp_reset=0, all counters and the shift register cleared. Applies from any state; a partial frame is abandoned, with no completion of the current bit.
- States: IDLE, START, DATA, STOP.
- IDLE: o_tx=1. If i_start==1: latch i_count into a 32-bit snapshot, byte index=0, go to START, o_busy=1. If CLEAR_ON_CAPTURE=1, o_comp_reset=1 for this one cycle.
- START: o_tx=0 for CLKS_PER_BIT cycles, load the current byte into the shift register, then go to DATA with bit index=0.
- DATA: o_tx = shift register LSB for CLKS_PER_BIT cycles per bit, 8 bits, LSB first. After bit 7, go to STOP.
- STOP: o_tx=1 for CLKS_PER_BIT cycles. Then:
  - If byte index<3: increment it and go to START. No idle gap between bytes.
  - If byte index==3: go to IDLE, o_busy=0, o_done=1 for one cycle.
- Byte order: byte0=snapshot[31:24], byte1=[23:16], byte2=[15:8], byte3=[7:0].
- i_start during a frame (o_busy=1) is ignored, not queued.
- i_start held high continuously: a new frame begins on the cycle o_busy falls (back-to-back frames). o_done and the new capture share that cycle.
- Changes to i_count after capture do not affect the frame in flight.
- Baud counter: counts 0..CLKS_PER_BIT-1, is 16 bits wide, and wraps to 0 at each bit boundary.

## Timing
- Capture edge T0 (IDLE, i_start=1): at T0+1, o_busy=1, o_tx=0 (start bit), and o_comp_reset=1 if enabled. o_comp_reset returns to 0 at T0+2.
- Each bit occupies exactly CLKS_PER_BIT cycles on o_tx, with no jitter or stretching.
- Frame length = 40*CLKS_PER_BIT cycles from T0+1.
- o_tx changes only at bit boundaries. It is registered, with no combinational path from inputs.
- Let TL be the last stop-bit cycle. At TL+1: o_busy=0, o_done=1, o_tx=1. o_done returns to 0 at TL+2 unless a new frame started (o_done never exceeds 1 cycle).
- Reset mid-frame at edge TR: o_tx=1 and o_busy=0 from TR onward, with no o_done pulse.

## Test plan
- Basic frame: CLKS_PER_BIT=4, i_count=0x12345678, pulse i_start 1 cycle -> o_tx bytes 0x12,0x34,0x56,0x78, each start=0, LSB first, stop=1; o_busy high exactly 160 cycles; a single o_done pulse.
- Snapshot stability: capture 0x000000FF, then change i_count to 0xFFFFFFFF at T0+2 -> transmitted bytes 0x00,0x00,0x00,0xFF.
- Clear pulse: CLEAR_ON_CAPTURE=1 -> o_comp_reset high only at T0+1. With CLEAR_ON_CAPTURE=0 -> o_comp_reset never high.
- Ignored request: i_start pulse at byte1 mid-DATA -> frame unchanged, one o_done, no second frame.
- Back-to-back: i_start held high, i_count=0xA5A5A5A5 -> second frame's start bit at the cycle after o_done, no idle bit between frames.
- Reset mid-frame: drive i_reset=0 during byte2 DATA -> at that edge o_tx=1, o_busy=0, no o_done. After release, a new i_start sends a complete correct frame.
